// File: rtl/sipo.sv
// Serial-in, parallel-out deserializer: collects width bits MSB-first and
// hands each word out on a valid/ready port, with a one-word skid in the shifter.
module sipo #(
    parameter int width = 4
) (
    input  logic                     clk_rx_in,
    input  logic                     rst,
    input  logic                     data_i,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic                     clear_in,
    output logic [width-1:0]         data_o,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [$clog2(width):0]   bit_count_o
);

    localparam int CW = $clog2(width) + 1;
    localparam logic [CW-1:0] LAST = CW'(width - 1);
    localparam logic [CW-1:0] FULL = CW'(width);

    logic [width-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic [width-1:0] data_q, data_d;
    logic             vout_q, vout_d;

    logic             accept, drain, complete;
    logic [width-1:0] sr_next;

    assign ready_out = !rst && !full_q && !clear_in;
    assign accept    = valid_in && ready_out;
    assign drain     = vout_q && ready_in;
    assign sr_next   = {sr_q[width-2:0], data_i};
    assign complete  = accept && (cnt_q == LAST);

    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        data_d = data_q;
        vout_d = vout_q;
        if (drain) vout_d = 1'b0;
        if (clear_in) begin
            // Output port is untouched by clear; only the collection side is dropped.
            sr_d   = '0;
            cnt_d  = '0;
            full_d = 1'b0;
        end else begin
            if (full_q && drain) begin
                data_d = sr_q;
                vout_d = 1'b1;
                full_d = 1'b0;
                cnt_d  = '0;
            end
            if (accept) begin
                sr_d  = sr_next;
                cnt_d = cnt_q + CW'(1);
                if (complete) begin
                    if (!vout_q || drain) begin
                        data_d = sr_next;
                        vout_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        full_d = 1'b1;
                        cnt_d  = FULL;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_rx_in) begin
        if (rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            data_q <= '0;
            vout_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
            data_q <= data_d;
            vout_q <= vout_d;
        end
    end

    assign data_o      = data_q;
    assign valid_out   = vout_q;
    assign bit_count_o = cnt_q;

endmodule

// File: doc/sipo.md
# sipo

Serial-in, parallel-out deserializer for the receive end of the serial link driven by the team's PISO transmitter. It collects `width` bits MSB-first from a serial valid/ready stream and presents each completed word on a parallel valid/ready interface. A one-word skid stage lets bit collection continue while the downstream consumer stalls.

## Interface
Parameters:
- `width`, default 4: bits per word; legal values are `width >= 2`.

Ports:
- `clk_rx_in`, input, 1: the single clock. All state changes on its rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `data_i`, input, 1: serial data bit. The first bit of a word is the word's MSB.
- `valid_in`, input, 1: `data_i` is valid this cycle.
- `ready_out`, output, 1: block can accept a serial bit this cycle.
- `clear_in`, input, 1: synchronous abort of the partially collected word.
- `data_o`, output, `width`: completed parallel word.
- `valid_out`, output, 1: `data_o` holds a valid word.
- `ready_in`, input, 1: downstream accepts `data_o` this cycle.
- `bit_count_o`, output, `$clog2(width)+1`: number of bits currently held in the shift register.

## Operation
- **State:**
  - shift register `sr[width-1:0]`
  - bit counter `cnt` (0..width)
  - `full` flag: `sr` holds a completed word that has not yet been transferred
  - output register `data_o`
  - `valid_out` flag
- **Serial acceptance:**
  - `ready_out = !rst && !full && !clear_in`.
  - This is the only combinational input-to-output path.
  - A bit is accepted when `valid_in && ready_out`.
  - On acceptance: `sr <= {sr[width-2:0], data_i}` and `cnt <= cnt+1`.
- **Parallel drain:** `drain = valid_out && ready_in`.
- **Word completion:** the accepted bit makes `cnt == width`.
  - If `!valid_out || drain`: load `data_o <= {sr[width-2:0], data_i}`, set `valid_out <= 1`, `cnt <= 0`. `full` stays 0.
  - Otherwise: keep the word in `sr`, set `full <= 1`, `cnt` stays at `width`.
- **Full-stage transfer:** when `full && drain`:
  - `data_o <= sr`, `valid_out` stays 1.
  - `full <= 0`, `cnt <= 0`.
- **Drain with no new word:** `drain` with no new word ready gives `valid_out <= 0`. `data_o` keeps its last value.
- **Stability:** `data_o` is stable while `valid_out && !ready_in`.
- **clear_in:**
  - Sets `cnt <= 0`, `full <= 0`, and discards `sr` contents.
  - Does not touch `data_o` or `valid_out`; a drain in the same cycle still completes.
  - A bit presented in the same cycle is not accepted, because `ready_out` is 0.
- **Priority:** `rst` > `clear_in` > normal operation.
- **Reset values:** `data_o = 0`, `valid_out = 0`, `sr = 0`, `cnt = 0`, `full = 0`, `bit_count_o = 0`. `ready_out = 0` while `rst` is high.
- **bit_count_o** equals `cnt`.

## Timing
- **Latency:** a word whose last bit is accepted at edge N has `valid_out = 1` and the word on `data_o` from edge N onward. This requires the output register to be free or draining at N.
- **Throughput:** sustained one word per `width` cycles with no bubbles when `valid_in` and `ready_in` are held high.
- **Backpressure:** with the output register occupied and a second word completed, `ready_out` is 0 from the edge that sets `full`.
- **Release:** `ready_out` returns to 1 in the cycle after the drain edge. The held word appears on `data_o` at that same edge.
- **Reset release:** `ready_out = 1` in the first cycle after `rst` deasserts, provided `clear_in = 0`.
- **Reset mid-operation:** `rst` asserted at any point clears everything at the next edge. Partial words, a held word and a pending output are all lost; no output handshake is completed.
- **Boundary cases:**
  - Completion and drain on the same edge: the new word replaces the old one with no `valid_out` gap.
  - `cnt` never exceeds `width`.

## Test plan
All scenarios use `width = 4`.

1. **Reset:**
   - Stimulus: hold `rst = 1` for 3 cycles with `valid_in = 1`.
   - Required: `valid_out = 0`, `data_o = 0`, `ready_out = 0`, `bit_count_o = 0` throughout; `ready_out = 1` the cycle after release.
2. **Single word:**
   - Stimulus: serial bits 1,0,1,1 on consecutive cycles with `ready_in = 1`.
   - Required: `valid_out = 1` with `data_o = 4'b1011` immediately after the 4th accept edge; `valid_out = 0` one cycle later.
3. **Back-to-back:**
   - Stimulus: stream 1011, 0110, 1111 continuously with `ready_in = 1`.
   - Required: `ready_out` stays 1; `data_o` shows 1011, 0110, 1111, each valid for exactly one cycle, 4 cycles apart, no gaps.
4. **Backpressure:**
   - Stimulus: `ready_in = 0`; send 1011 then 0110, then offer a 9th bit; later raise `ready_in` for one cycle.
   - Required before release: `data_o` holds 1011 and stays stable; `ready_out` falls after the 8th bit and the 9th bit is not accepted.
   - Required after release: 1011 is consumed, `data_o = 0110` on the next cycle, and `ready_out = 1` again.
5. **Clear:**
   - Stimulus: send 2 bits (`bit_count_o = 2`), pulse `clear_in`, then send 0,0,0,1.
   - Required: `bit_count_o = 0` after the clear; the output word is 0001.
   - Required for a clear issued while 1011 is held: `data_o` stays 1011.
6. **Reset mid-operation:**
   - Stimulus: hold `valid_out` with 1011 undrained and 2 bits partially collected, then pulse `rst`.
   - Required: `valid_out = 0`, `data_o = 0`, `bit_count_o = 0`; the next 4 bits form a fresh word.
